// File: rtl/reg_bank_wb.sv
// Write-back register bank: 32 architectural registers with two registered
// read ports (write-first bypass) and a per-register busy scoreboard.
module reg_bank_wb #(
    parameter int unsigned SP_INDEX = 29,
    parameter int unsigned SP_RESET = 227,
    parameter int unsigned RA_INDEX = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_write,
    input  logic [4:0]  write_reg,
    input  logic [31:0] write_data,
    input  logic [4:0]  read_reg_a,
    input  logic [4:0]  read_reg_b,
    output logic [31:0] read_data_a,
    output logic [31:0] read_data_b,
    input  logic        reserve,
    input  logic [4:0]  reserve_reg,
    output logic        busy_a,
    output logic        busy_b,
    output logic [31:0] sp_out,
    output logic [31:0] ra_out
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned NREGS  = 32;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_next;

    logic              write_en;
    logic              bypass_a;
    logic              bypass_b;

    // Register 0 is hard-wired: writes to it are dropped here.
    assign write_en = reg_write && (write_reg != IDX_W'(0));
    assign bypass_a = write_en && (write_reg == read_reg_a);
    assign bypass_b = write_en && (write_reg == read_reg_b);

    // Register array; SP comes out of reset at its initial stack top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= (i == int'(SP_INDEX)) ? DATA_W'(SP_RESET) : '0;
            end
        end else if (write_en) begin
            regs[write_reg] <= write_data;
        end
    end

    // Read ports see this edge's write (write-first).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data_a <= '0;
            read_data_b <= '0;
        end else begin
            read_data_a <= bypass_a ? write_data : regs[read_reg_a];
            read_data_b <= bypass_b ? write_data : regs[read_reg_b];
        end
    end

    // Scoreboard: a write retires the pending producer, a same-edge reserve
    // installs a new one and wins.
    always_comb begin
        busy_next = busy;
        if (reg_write) begin
            busy_next[write_reg] = 1'b0;
        end
        if (reserve) begin
            busy_next[reserve_reg] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign busy_a = busy[read_reg_a];
    assign busy_b = busy[read_reg_b];
    assign sp_out = regs[IDX_W'(SP_INDEX)];
    assign ra_out = regs[IDX_W'(RA_INDEX)];

endmodule

// File: tb/tb_reg_bank_wb.sv
// Directed vector bench for reg_bank_wb: table of per-edge stimulus with
// expected post-edge outputs, plus a hand-written mid-operation reset sequence.
module tb_reg_bank_wb;

    logic        clk;
    logic        reset;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg_a;
    logic [4:0]  read_reg_b;
    logic [31:0] read_data_a;
    logic [31:0] read_data_b;
    logic        reserve;
    logic [4:0]  reserve_reg;
    logic        busy_a;
    logic        busy_b;
    logic [31:0] sp_out;
    logic [31:0] ra_out;

    int total;
    int bad;

    reg_bank_wb dut (
        .clk         (clk),
        .reset       (reset),
        .reg_write   (reg_write),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .read_reg_a  (read_reg_a),
        .read_reg_b  (read_reg_b),
        .read_data_a (read_data_a),
        .read_data_b (read_data_b),
        .reserve     (reserve),
        .reserve_reg (reserve_reg),
        .busy_a      (busy_a),
        .busy_b      (busy_b),
        .sp_out      (sp_out),
        .ra_out      (ra_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        rs;
        logic [4:0]  rr;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_ba;
        logic        exp_bb;
        logic [31:0] exp_sp;
        logic [31:0] exp_ra;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic we, logic [4:0] wr, logic [31:0] wd,
                                logic [4:0] ra, logic [4:0] rb,
                                logic rs, logic [4:0] rr,
                                logic [31:0] ea, logic [31:0] eb,
                                logic eba, logic ebb,
                                logic [31:0] esp, logic [31:0] era);
        vec_t v;
        v.we = we; v.wr = wr; v.wd = wd; v.ra = ra; v.rb = rb;
        v.rs = rs; v.rr = rr; v.exp_a = ea; v.exp_b = eb;
        v.exp_ba = eba; v.exp_bb = ebb; v.exp_sp = esp; v.exp_ra = era;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                             input logic eba, input logic ebb,
                             input logic [31:0] esp, input logic [31:0] era);
        check({tag, ".read_data_a"}, read_data_a, ea);
        check({tag, ".read_data_b"}, read_data_b, eb);
        check({tag, ".busy_a"}, 32'(busy_a), 32'(eba));
        check({tag, ".busy_b"}, 32'(busy_b), 32'(ebb));
        check({tag, ".sp_out"}, sp_out, esp);
        check({tag, ".ra_out"}, ra_out, era);
    endtask

    task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb,
                         input logic rs, input logic [4:0] rr);
        reg_write = we; write_reg = wr; write_data = wd;
        read_reg_a = ra; read_reg_b = rb; reserve = rs; reserve_reg = rr;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //         we   wr     wd            ra     rb     rs   rr     exp_a         exp_b         ba    bb    sp            ra_out
        vecs[0]  = mk(1'b0, 5'd0,  32'h0,        5'd29, 5'd0,  1'b0, 5'd0,  32'd227,      32'h0,        1'b0, 1'b0, 32'd227,      32'h0);
        vecs[1]  = mk(1'b1, 5'd31, 32'h00400010, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 32'd227,      32'h00400010);
        vecs[2]  = mk(1'b0, 5'd0,  32'h0,        5'd0,  5'd31, 1'b0, 5'd0,  32'h0,        32'h00400010, 1'b0, 1'b0, 32'd227,      32'h00400010);
        vecs[3]  = mk(1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  1'b0, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 32'd227,      32'h00400010);
        vecs[4]  = mk(1'b0, 5'd0,  32'h0,        5'd8,  5'd5,  1'b1, 5'd8,  32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 32'd227,      32'h00400010);
        vecs[5]  = mk(1'b1, 5'd8,  32'd7,        5'd8,  5'd5,  1'b0, 5'd0,  32'd7,        32'hDEADBEEF, 1'b0, 1'b0, 32'd227,      32'h00400010);
        vecs[6]  = mk(1'b1, 5'd8,  32'd9,        5'd8,  5'd5,  1'b1, 5'd8,  32'd9,        32'hDEADBEEF, 1'b1, 1'b0, 32'd227,      32'h00400010);
        vecs[7]  = mk(1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd8,  1'b1, 5'd0,  32'h0,        32'd9,        1'b0, 1'b1, 32'd227,      32'h00400010);
        vecs[8]  = mk(1'b1, 5'd29, 32'h100,      5'd29, 5'd3,  1'b1, 5'd3,  32'h100,      32'h0,        1'b0, 1'b1, 32'h100,      32'h00400010);
        vecs[9]  = mk(1'b0, 5'd0,  32'h0,        5'd12, 5'd31, 1'b1, 5'd12, 32'h0,        32'h00400010, 1'b1, 1'b0, 32'h100,      32'h00400010);
        vecs[10] = mk(1'b1, 5'd20, 32'hABC,      5'd20, 5'd12, 1'b0, 5'd0,  32'hABC,      32'h0,        1'b0, 1'b1, 32'h100,      32'h00400010);
        vecs[11] = mk(1'b1, 5'd12, 32'h77,       5'd12, 5'd3,  1'b1, 5'd12, 32'h77,       32'h0,        1'b1, 1'b1, 32'h100,      32'h00400010);
        vecs[12] = mk(1'b1, 5'd12, 32'h88,       5'd12, 5'd3,  1'b0, 5'd0,  32'h88,       32'h0,        1'b0, 1'b1, 32'h100,      32'h00400010);

        reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        check_all("in_reset", 32'h0, 32'h0, 1'b0, 1'b0, 32'd227, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].we, vecs[i].wr, vecs[i].wd, vecs[i].ra, vecs[i].rb,
                  vecs[i].rs, vecs[i].rr);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b,
                      vecs[i].exp_ba, vecs[i].exp_bb, vecs[i].exp_sp, vecs[i].exp_ra);
        end

        // Asynchronous reset between edges: SP=0x100 and reg 3 busy beforehand.
        drive(1'b0, 5'd0, 32'h0, 5'd29, 5'd3, 1'b0, 5'd0);
        @(posedge clk);
        #1;
        check_all("pre_reset", 32'h100, 32'h0, 1'b0, 1'b1, 32'h100, 32'h00400010);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", 32'h0, 32'h0, 1'b0, 1'b0, 32'd227, 32'h0);

        // Edge while reset is high must not write, read or reserve.
        drive(1'b1, 5'd29, 32'h500, 5'd29, 5'd3, 1'b1, 5'd3);
        @(posedge clk);
        #1;
        check_all("edge_in_reset", 32'h0, 32'h0, 1'b0, 1'b0, 32'd227, 32'h0);

        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd29, 5'd3, 1'b0, 5'd0);
        @(posedge clk);
        #1;
        check_all("post_reset", 32'd227, 32'h0, 1'b0, 1'b0, 32'd227, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
